// File: rtl/priority_encoder_rr_arbiter.sv
// Priority encoder / arbiter with a registered, handshaked grant output.
// Selects a winner from N request lines. In fixed mode the highest index wins.
// In round-robin mode the search starts at a rotating pointer and moves downward.
// A grant stays stable until the consumer accepts it. Back-to-back accepts
// reload the next winner in the same cycle, so no idle cycle is inserted.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no grant presented; out_onehot is 0; out_index keeps last value
// S_VALID | grant presented; out_index/out_onehot held until accepted
module priority_encoder_rr_arbiter #(
  parameter  int N          = 8,
  parameter  int RESET_MODE = 0,
  localparam int W          = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_lines,
  input  logic         mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_index,
  output logic [N-1:0] out_onehot
);

  // Reject illegal parameter values at elaboration.
  if (N < 2 || RESET_MODE < 0 || RESET_MODE > 1) begin : g_bad_param
    $error("priority_encoder_rr_arbiter: N must be >= 2 and RESET_MODE 0 or 1");
  end

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_VALID = 1'b1
  } state_t;

  state_t       state, state_nxt;
  logic [W-1:0] ptr, ptr_nxt;
  logic [W-1:0] index_nxt;
  logic [N-1:0] onehot_nxt;

  logic         accept;
  logic [W-1:0] ptr_eff;
  logic [W-1:0] fix_idx;
  logic [W-1:0] rr_idx;
  logic         rr_found;
  logic [W-1:0] win_idx;
  logic [N-1:0] win_onehot;

  assign out_valid = (state == S_VALID);
  assign accept    = out_valid && out_ready;

  // On an accept in round-robin mode the search starts just below the grant
  // being retired, so the retiring index becomes the lowest priority.
  always_comb begin
    ptr_eff = ptr;
    if (accept && mode) begin
      if (out_index == '0) ptr_eff = W'(N - 1);
      else                 ptr_eff = out_index - W'(1);
    end
  end

  // Fixed priority: the highest set index wins (later iterations overwrite).
  always_comb begin
    fix_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (in_lines[i]) fix_idx = W'(i);
    end
  end

  // Round-robin: first set line scanning downward from ptr_eff, wrapping 0 -> N-1.
  always_comb begin
    int           k;
    logic [W-1:0] kk;
    rr_idx   = '0;
    rr_found = 1'b0;
    k        = 0;
    kk       = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr_eff) - i;
      if (k < 0) k = k + N;
      kk = W'(k);
      if (!rr_found && in_lines[kk]) begin
        rr_idx   = kk;
        rr_found = 1'b1;
      end
    end
  end

  // Select the winner for the current mode and decode it to one-hot.
  always_comb begin
    win_idx    = mode ? rr_idx : fix_idx;
    win_onehot = {{(N-1){1'b0}}, 1'b1} << win_idx;
  end

  // Next-state and output-register logic for the grant FSM.
  always_comb begin
    state_nxt  = state;
    index_nxt  = out_index;
    onehot_nxt = out_onehot;
    ptr_nxt    = ptr;

    if (accept && mode) ptr_nxt = ptr_eff;

    case (state)
      S_IDLE: begin
        onehot_nxt = '0;
        if (|in_lines) begin
          index_nxt  = win_idx;
          onehot_nxt = win_onehot;
          state_nxt  = S_VALID;
        end
      end
      S_VALID: begin
        if (accept) begin
          if (|in_lines) begin
            index_nxt  = win_idx;
            onehot_nxt = win_onehot;
          end else begin
            onehot_nxt = '0;
            state_nxt  = S_IDLE;
          end
        end
      end
      default: begin
        onehot_nxt = '0;
        state_nxt  = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any presented grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      out_index  <= '0;
      out_onehot <= '0;
      ptr        <= W'(N - 1);
    end else begin
      state      <= state_nxt;
      out_index  <= index_nxt;
      out_onehot <= onehot_nxt;
      ptr        <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_priority_encoder_rr_arbiter.sv
// Directed bench for priority_encoder_rr_arbiter (N = 8).
// Each record gives the inputs applied before a rising edge and the outputs
// expected just after that edge.
module tb_priority_encoder_rr_arbiter;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in_lines;
  logic         mode;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_index;
  logic [N-1:0] out_onehot;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string        name;
    logic         rst;
    logic [N-1:0] in_lines;
    logic         mode;
    logic         out_ready;
    logic         exp_valid;
    logic [W-1:0] exp_index;
    logic [N-1:0] exp_onehot;
  } vec_t;

  vec_t vecs[$];

  priority_encoder_rr_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_lines   (in_lines),
    .mode       (mode),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_index  (out_index),
    .out_onehot (out_onehot)
  );

  always #5 clk = ~clk;

  task automatic add(input string name, input logic r, input logic [N-1:0] lines,
                     input logic m, input logic rdy, input logic ev,
                     input logic [W-1:0] ei, input logic [N-1:0] eo);
    vec_t v;
    v.name = name; v.rst = r; v.in_lines = lines; v.mode = m; v.out_ready = rdy;
    v.exp_valid = ev; v.exp_index = ei; v.exp_onehot = eo;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic ev, input logic [W-1:0] ei,
                       input logic [N-1:0] eo);
    tests_run++;
    if (out_valid !== ev || out_index !== ei || out_onehot !== eo) begin
      tests_failed++;
      $display("FAIL %s: got valid=%0b index=%0d onehot=%02h, expected valid=%0b index=%0d onehot=%02h",
               name, out_valid, out_index, out_onehot, ev, ei, eo);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] lines, input logic m, input logic rdy);
    rst = r; in_lines = lines; mode = m; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_lines = 8'hFF; mode = 1'b0; out_ready = 1'b0;

    // Reset held two cycles with all requests pending.
    add("rst0",      1, 8'hFF, 0, 0, 0, 0, 8'h00);
    add("rst1",      1, 8'hFF, 0, 0, 0, 0, 8'h00);
    // Fixed priority, 0010_0110 held: highest index 5 every cycle.
    add("fix_a",     0, 8'h26, 0, 1, 1, 5, 8'h20);
    add("fix_b",     0, 8'h26, 0, 1, 1, 5, 8'h20);
    add("fix_c",     0, 8'h26, 0, 1, 1, 5, 8'h20);
    // Accept with no requests: back to idle, index held, onehot cleared.
    add("drop_idle", 0, 8'h00, 0, 1, 0, 5, 8'h00);
    // Round-robin with all requests: 7 down to 0 then wrap to 7.
    add("rr7",       0, 8'hFF, 1, 1, 1, 7, 8'h80);
    add("rr6",       0, 8'hFF, 1, 1, 1, 6, 8'h40);
    add("rr5",       0, 8'hFF, 1, 1, 1, 5, 8'h20);
    add("rr4",       0, 8'hFF, 1, 1, 1, 4, 8'h10);
    add("rr3",       0, 8'hFF, 1, 1, 1, 3, 8'h08);
    add("rr2",       0, 8'hFF, 1, 1, 1, 2, 8'h04);
    add("rr1",       0, 8'hFF, 1, 1, 1, 1, 8'h02);
    add("rr0",       0, 8'hFF, 1, 1, 1, 0, 8'h01);
    add("rr7_wrap",  0, 8'hFF, 1, 1, 1, 7, 8'h80);
    // Reset mid-grant, then round-robin between lines 7 and 0.
    add("rst_mid",   1, 8'h81, 1, 1, 0, 0, 8'h00);
    add("alt7a",     0, 8'h81, 1, 1, 1, 7, 8'h80);
    add("alt0a",     0, 8'h81, 1, 1, 1, 0, 8'h01);
    add("alt7b",     0, 8'h81, 1, 1, 1, 7, 8'h80);
    add("alt0b",     0, 8'h81, 1, 1, 1, 0, 8'h01);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].in_lines, vecs[i].mode, vecs[i].out_ready);
      check(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_index, vecs[i].exp_onehot);
    end

    // Backpressure: present grant 3, change requests and mode while stalled.
    step(0, 8'h00, 1, 1); check("bp_idle",  0, 0, 8'h00);
    step(0, 8'h08, 0, 0); check("bp_load3", 1, 3, 8'h08);
    for (int c = 0; c < 4; c++) begin
      step(0, 8'h80, (c == 2) ? 1'b1 : 1'b0, 0);
      check($sformatf("bp_hold%0d", c), 1, 3, 8'h08);
    end
    step(0, 8'h80, 0, 1); check("bp_next7", 1, 7, 8'h80);
    step(0, 8'h00, 0, 1); check("bp_idle2", 0, 7, 8'h00);

    // Reset while a round-robin grant is presented; first grant after is 7.
    step(0, 8'hFF, 1, 1); check("rst_g7",   1, 7, 8'h80);
    step(0, 8'hFF, 1, 1); check("rst_g6",   1, 6, 8'h40);
    step(1, 8'hFF, 1, 1); check("rst_kill", 0, 0, 8'h00);
    step(0, 8'hFF, 1, 1); check("rst_first",1, 7, 8'h80);

    // Round-robin pointer must not advance while stalled.
    step(0, 8'hFF, 1, 0); check("rr_stall", 1, 7, 8'h80);
    step(0, 8'hFF, 1, 1); check("rr_after", 1, 6, 8'h40);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
